// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone timeout bridge: classic-cycle encodings,
// FSM state encoding and the wait-counter sizing helper.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to count 0 .. value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/wb_sat_counter.sv
// Saturating event counter: advances on inc and sticks at all-ones.
module wb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered single-slave Wishbone bridge that turns every transfer into a classic
// cycle and kills transfers the slave never terminates with an error response.
module wb_timeout_bridge
  import wb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [aw-1:0]    wbm_adr_i,
  input  logic [dw-1:0]    wbm_dat_i,
  input  logic [3:0]       wbm_sel_i,
  input  logic             wbm_we_i,
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  input  logic [2:0]       wbm_cti_i,
  input  logic [1:0]       wbm_bte_i,
  output logic [dw-1:0]    wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_err_o,
  output logic             wbm_rty_o,
  output logic [aw-1:0]    wbs_adr_o,
  output logic [dw-1:0]    wbs_dat_o,
  output logic [3:0]       wbs_sel_o,
  output logic             wbs_we_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  output logic [2:0]       wbs_cti_o,
  output logic [1:0]       wbs_bte_o,
  input  logic [dw-1:0]    wbs_dat_i,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,
  input  logic             wbs_rty_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] timeout_cnt_o,
  output logic [aw-1:0]    timeout_adr_o
);

  localparam int                WCNT_W    = clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic              start, abort, term_err, term_ack, term_rty, expire;

  // Bursts are flattened to classic beats, so the burst hints are dropped here.
  logic unused_burst;
  assign unused_burst = ^{wbm_cti_i, wbm_bte_i};

  assign wbs_cti_o = CTI_CLASSIC;
  assign wbs_bte_o = BTE_LINEAR;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    term_err  = 1'b0;
    term_ack  = 1'b0;
    term_rty  = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: if (wbm_cyc_i && wbm_stb_i) begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      // Master abort beats any slave answer; a slave answer beats expiry.
      WAIT: begin
        if (!wbm_cyc_i) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (wbs_err_i) begin
          term_err  = 1'b1;
          state_nxt = RESP;
        end else if (wbs_ack_i) begin
          term_ack  = 1'b1;
          state_nxt = RESP;
        end else if (wbs_rty_i) begin
          term_rty  = 1'b1;
          state_nxt = RESP;
        end else if (wcnt == WCNT_LAST) begin
          expire    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_adr_o     <= '0;
      wbs_dat_o     <= '0;
      wbs_sel_o     <= '0;
      wbs_we_o      <= 1'b0;
      wbs_cyc_o     <= 1'b0;
      wbs_stb_o     <= 1'b0;
      wbm_dat_o     <= '0;
      wbm_ack_o     <= 1'b0;
      wbm_err_o     <= 1'b0;
      wbm_rty_o     <= 1'b0;
      timeout_o     <= 1'b0;
      timeout_adr_o <= '0;
      wcnt          <= '0;
    end else begin
      // Response bits are recomputed every edge, which makes them one-cycle pulses.
      wbm_ack_o <= term_ack;
      wbm_err_o <= term_err | expire;
      wbm_rty_o <= term_rty;
      timeout_o <= expire;
      if (start) begin
        wbs_adr_o <= wbm_adr_i;
        wbs_dat_o <= wbm_dat_i;
        wbs_sel_o <= wbm_sel_i;
        wbs_we_o  <= wbm_we_i;
        wbs_cyc_o <= 1'b1;
        wbs_stb_o <= 1'b1;
        wcnt      <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
      end
      if (abort || term_err || term_ack || term_rty || expire) begin
        wbs_cyc_o <= 1'b0;
        wbs_stb_o <= 1'b0;
      end
      if (term_ack) wbm_dat_o <= wbs_dat_i;
      if (expire)   timeout_adr_o <= wbs_adr_o;
    end
  end

  wb_sat_counter #(
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .inc   (expire),
    .count (timeout_cnt_o)
  );

endmodule
